// File: rtl/monochrome_ctrl.sv
// monochrome_ctrl
//   ZX-UNO register that selects the monochrome mode of the colour path.
//   Software writes a pending mode. A keyboard hotkey can also advance the
//   pending mode. The pending mode is applied only on a vsync rising edge,
//   so the colour path never changes mode mid-frame.
//
//   Build option: define MONOCHROME_HOTKEY_EN to build the hotkey
//   synchroniser, the hold-off counter and the lock gating. Without it the
//   hotkey input is ignored. The lock bit is still writable and readable.
//
// Parameters
//   MONOADDR  ZX-UNO register address of this register
//   HOLDOFF   hotkey hold-off length in clk cycles (1 .. 2^20-1)
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   zxuno_addr            selected ZX-UNO register address
//   zxuno_regrd/_regwr    register read/write strobes (level, active-high)
//   din                   write data: [7] lock, [1:0] mode
//   dout, oe              read data {lock, dirty, 0000, pending}; oe while driving
//   hotkey                asynchronous mode-cycle key level
//   vsync                 vertical sync (clk domain, active-high)
//   monochrome_selection  applied mode: 00 colour, 01 green, 10 amber, 11 B&W

module monochrome_ctrl #(
  parameter logic [7:0]  MONOADDR = 8'h0F,
  parameter logic [19:0] HOLDOFF  = 20'd1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe,
  input  logic       hotkey,
  input  logic       vsync,
  output logic [1:0] monochrome_selection
);

  logic [1:0] pending, pending_d;
  logic [1:0] applied, applied_d;
  logic       lock, lock_d;
  logic       dirty, dirty_d;
  logic       vsync_q;

  logic       write_hit;
  logic       apply;
  logic       hotkey_accept;

  // Bits 6:2 of the write data carry no state.
  logic [4:0] unused_din;
  assign unused_din = din[6:2];

  assign write_hit = zxuno_regwr && (zxuno_addr == MONOADDR);
  assign apply     = vsync && !vsync_q;

`ifdef MONOCHROME_HOTKEY_EN
  logic        hk_sync1, hk_sync2, hk_hist;
  logic [19:0] holdoff;

  // A write hit in the same cycle wins over the hotkey edge. The edge is then
  // dropped, not deferred, and the hold-off counter is not loaded.
  assign hotkey_accept = hk_sync2 && !hk_hist && (holdoff == 20'd0) &&
                         !lock && !write_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hk_sync1 <= 1'b0;
      hk_sync2 <= 1'b0;
      hk_hist  <= 1'b0;
      holdoff  <= 20'd0;
    end else begin
      hk_sync1 <= hotkey;
      hk_sync2 <= hk_sync1;
      hk_hist  <= hk_sync2;
      if (hotkey_accept)
        holdoff <= HOLDOFF;
      else if (holdoff != 20'd0)
        holdoff <= holdoff - 20'd1;
    end
  end
`else
  logic unused_hotkey;
  assign unused_hotkey = hotkey;
  assign hotkey_accept = 1'b0;
`endif

  // NOTE: every signal driven here gets its default first. A path that leaves
  // a signal unassigned would infer a latch.
  always_comb begin
    pending_d = pending;
    applied_d = applied;
    lock_d    = lock;
    dirty_d   = dirty;

    if (apply) begin
      applied_d = pending;
      dirty_d   = 1'b0;
    end

    // Compare the new pending value with the value applied at the end of this
    // cycle. An apply in the same cycle therefore takes the pre-write pending.
    if (write_hit) begin
      pending_d = din[1:0];
      lock_d    = din[7];
      dirty_d   = (din[1:0] != applied_d);
    end else if (hotkey_accept) begin
      pending_d = pending + 2'd1;
      dirty_d   = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments. All flops then
  // sample the pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 2'b00;
      applied <= 2'b00;
      lock    <= 1'b0;
      dirty   <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      pending <= pending_d;
      applied <= applied_d;
      lock    <= lock_d;
      dirty   <= dirty_d;
      vsync_q <= vsync;
    end
  end

  assign monochrome_selection = applied;

  assign oe   = zxuno_regrd && (zxuno_addr == MONOADDR);
  assign dout = oe ? {lock, dirty, 4'b0000, pending} : 8'h00;

endmodule

// File: doc/monochrome_ctrl.md
MONOCHROME_CTRL -- requirements
Module: monochrome_ctrl

Interface
REQ-001 Parameter MONOADDR, default 8'h0F: ZX-UNO register address of the monochrome control register.
REQ-002 Parameter HOLDOFF, default 20'd1000000: hotkey hold-off length in clk cycles; legal range 1..2^20-1.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 zxuno_addr  input  8  currently selected ZX-UNO register address.
REQ-007 zxuno_regrd  input  1  register read strobe, level, active-high.
REQ-008 zxuno_regwr  input  1  register write strobe, level, active-high.
REQ-009 din  input  8  write data.
REQ-010 dout  output  8  read data.
REQ-011 oe  output  1  high while dout drives the bus.
REQ-012 hotkey  input  1  asynchronous level from the keyboard block; high while the mode-cycle key combination is held.
REQ-013 vsync  input  1  vertical sync in clk domain, active-high.
REQ-014 monochrome_selection  output  2  applied mode to the colour path: 00 colour, 01 green, 10 amber, 11 black-and-white.

Function
REQ-015 Internal state: pending[1:0], applied[1:0], lock, dirty, hotkey synchroniser (2 flops plus 1 edge-history flop), holdoff counter (20 bits).
REQ-016 Write hit is zxuno_regwr=1 and zxuno_addr=MONOADDR; on each hit cycle: pending<=din[1:0] and lock<=din[7]; dirty<=1 only if din[1:0]!=applied. Repeated hit cycles are idempotent.
REQ-017 Read: oe=zxuno_regrd and zxuno_addr=MONOADDR, combinational; dout={lock,dirty,4'b0000,pending} when oe=1, else 8'h00.
REQ-018 Hotkey edge is a rising edge of the synchronised hotkey (2 flops plus the edge-history flop, latency 3 clk).
REQ-019 A hotkey edge is accepted only when holdoff=0 and lock=0 and there is no write hit in the same cycle.
REQ-020 An accepted hotkey edge sets pending<=pending+1 mod 4 (11->00 wraps), sets dirty<=1 and loads holdoff<=HOLDOFF.
REQ-021 Holdoff decrements by 1 per clk while nonzero; edges arriving while nonzero are discarded, not queued.
REQ-022 A simultaneous write hit and hotkey edge: the write takes effect, the edge is discarded and holdoff is unchanged.
REQ-023 Apply: on the cycle after a vsync rising edge (vsync=1, previous vsync=0), applied<=pending and dirty<=0.
REQ-024 A write hit in the same cycle as the apply cycle: applied takes the pre-write pending; the new pending is stored; dirty<=1 if the new pending differs from it.
REQ-025 monochrome_selection=applied, registered, so the output changes only on an apply cycle; it never changes mid-frame.
REQ-026 vsync held high does not produce further apply cycles; only a new 0->1 transition does.

Reset
REQ-027 While rst_n=0: pending=00, applied=00, monochrome_selection=00, lock=0, dirty=0, holdoff=0, synchroniser flops=0, vsync history=0.
REQ-028 dout and oe follow REQ-017 combinationally during reset (dout=8'h00 at reset register values when read).
REQ-029 Reset asserted mid-holdoff or with dirty=1 discards the pending change; after release the first vsync edge applies 00.

Configuration
REQ-030 Macro MONOCHROME_HOTKEY_EN defined: hotkey path, holdoff counter and lock gating are implemented as in REQ-018..022.
REQ-031 Macro MONOCHROME_HOTKEY_EN undefined: the hotkey input is ignored and no holdoff logic is built; lock stays writable and readable; register and apply behaviour are unchanged.

Verification (HOLDOFF=8, MONOADDR=8'h0F)
REQ-032 Write 8'h02 to 8'h0F, then read -> dout=8'h42 and monochrome_selection=00; after a vsync 0->1 -> selection=10 one clk later, and a read gives 8'h02.
REQ-033 Four hotkey pulses spaced 20 clk, each followed by a vsync edge -> selection sequence 01,10,11,00.
REQ-034 Two hotkey rising edges 4 clk apart -> pending advances by 1 only; a third edge 12 clk after the first is accepted.
REQ-035 Write 8'h81 (lock), then hotkey pulse -> pending stays 01 and a read gives 8'hC1 before vsync.
REQ-036 Write hit and hotkey edge in the same cycle with data 8'h03 -> pending=11 and holdoff remains 0.
REQ-037 Assert rst_n=0 for 2 clk during holdoff with pending=10 not yet applied -> all state 0 and selection=00 after release; without MONOCHROME_HOTKEY_EN, hotkey pulses leave pending unchanged.
